ahb_data_master: RTL and testbench

AHB-Lite initiator for the RISC-V core's load/store path. It accepts one load or store request per cycle from the core's memory stage and drives the AHB address and data phases, overlapping them in a pipeline. It returns read data and error status in order and handles wait states and the two-cycle ERROR response. It is the other end of the data-memory slave path.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/ahb_data_master.sv | 91 +++++++++
 tb/tb_ahb_data_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the data-side initiator.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [3:0] HPROT_DATA = 4'b0011;

endpackage

// File: rtl/ahb_data_master.sv
// AHB-Lite load/store initiator: pipelined address/data phases, in-order
// responses, wait-state stall and two-cycle ERROR with cancel of the queued request.
module ahb_data_master
    import ahb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic        is_signed,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_valid must not depend on req_ready, and resp_valid is a single-cycle pulse
    // with no back-pressure from the core.
    logic        ap_valid;
    logic [31:0] ap_wdata;
    logic        dp_valid;
    logic        cancel_pending;

    logic accept;
    logic err_first;
    logic cancel_resp;

    always_comb begin
        req_ready   = hready && !cancel_pending;
        accept      = req_valid && req_ready;
        err_first   = dp_valid && hresp && !hready;
        // The cancelled request reports only once the erroring transfer has left DP.
        cancel_resp = cancel_pending && !dp_valid;
        resp_valid  = (dp_valid && hready) || cancel_resp;
        resp_err    = (dp_valid && hready && hresp) || cancel_resp;
        resp_rdata  = hrdata;
        htrans      = ap_valid ? NONSEQ : IDLE;
        hprot       = HPROT_DATA;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ap_valid       <= 1'b0;
            haddr          <= 32'h0;
            hwrite         <= 1'b0;
            hsize          <= HSIZE_WORD;
            is_signed      <= 1'b0;
            ap_wdata       <= 32'h0;
            dp_valid       <= 1'b0;
            hwdata         <= 32'h0;
            cancel_pending <= 1'b0;
        end else begin
            if (hready) begin
                dp_valid <= ap_valid;
                hwdata   <= ap_wdata;
                ap_valid <= accept;
                if (accept) begin
                    haddr     <= req_addr;
                    hwrite    <= req_write;
                    hsize     <= req_size;
                    is_signed <= req_signed;
                    ap_wdata  <= req_wdata;
                end
            end else if (err_first) begin
                // Drop the queued address so the second ERROR cycle shows IDLE.
                ap_valid <= 1'b0;
            end

            if (err_first && ap_valid) begin
                cancel_pending <= 1'b1;
            end else if (cancel_resp) begin
                cancel_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_data_master.sv
// Directed self-checking bench for ahb_data_master with a hand-driven AHB slave.
module tb_ahb_data_master;
    import ahb_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        is_signed;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int errors = 0;
    int checks = 0;
    logic issued_204;
    logic [31:0] held_addr;
    logic [31:0] held_wdata;

    ahb_data_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hprot(hprot), .is_signed(is_signed), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bus monitor: an address phase is taken only when hready is high
    always @(negedge clk) begin
        if (htrans == 2'b10 && hready && haddr == 32'h204) issued_204 <= 1'b1;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 3'b010;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        hready     = 1'b1;
        hresp      = 1'b0;
        hrdata     = 32'h0;
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        step(); step();
        #2;
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %h exp 0", htrans); end
        checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h exp 0", haddr); end
        checks++; if (hwrite !== 1'b0) begin errors++; $display("FAIL rst_hwrite: got %b exp 0", hwrite); end
        checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL rst_hsize: got %b exp 010", hsize); end
        checks++; if (hprot !== 4'b0011) begin errors++; $display("FAIL rst_hprot: got %b exp 0011", hprot); end
        checks++; if (is_signed !== 1'b0) begin errors++; $display("FAIL rst_is_signed: got %b exp 0", is_signed); end
        checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h exp 0", hwdata); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b exp 0", resp_err); end
        reset = 1'b1;
        step(); #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_single_read();
        step(); drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h1000_0004, 32'h0); #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", req_ready); end
        step(); drive_idle(); #2;
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL rd_htrans: got %h exp 2", htrans); end
        checks++; if (haddr !== 32'h1000_0004) begin errors++; $display("FAIL rd_haddr: got %h exp 10000004", haddr); end
        checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL rd_hsize: got %b exp 010", hsize); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_resp: got %b exp 0", resp_valid); end
        step(); hrdata = 32'hDEAD_BEEF; #2;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b exp 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h exp deadbeef", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b exp 0", resp_err); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rd_htrans_idle: got %h exp 0", htrans); end
        step(); drive_idle(); #2;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_once: got %b exp 0", resp_valid); end
    endtask

    task automatic test_pipelined();
        step(); drive_req(1'b1, HSIZE_WORD, 1'b0, 32'h100, 32'h1122_3344);
        step(); drive_req(1'b0, HSIZE_BYTE, 1'b1, 32'h103, 32'h0); #2;
        checks++; if (haddr !== 32'h100 || hwrite !== 1'b1 || htrans !== 2'b10) begin errors++; $display("FAIL pl_st_addr: got %h/%b/%h exp 100/1/2", haddr, hwrite, htrans); end
        step(); drive_idle(); #2;
        checks++; if (hwdata !== 32'h1122_3344) begin errors++; $display("FAIL pl_hwdata: got %h exp 11223344", hwdata); end
        checks++; if (haddr !== 32'h103) begin errors++; $display("FAIL pl_ld_haddr: got %h exp 103", haddr); end
        checks++; if (hsize !== 3'b000) begin errors++; $display("FAIL pl_ld_hsize: got %b exp 000", hsize); end
        checks++; if (is_signed !== 1'b1) begin errors++; $display("FAIL pl_is_signed: got %b exp 1", is_signed); end
        checks++; if (hwrite !== 1'b0 || htrans !== 2'b10) begin errors++; $display("FAIL pl_ld_ctrl: got %b/%h exp 0/2", hwrite, htrans); end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL pl_st_resp: got %b/%b exp 1/0", resp_valid, resp_err); end
        step(); hrdata = 32'hFFFF_FF80; #2;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL pl_ld_resp: got %b/%h exp 1/ffffff80", resp_valid, resp_rdata); end
        step(); drive_idle(); #2;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL pl_resp_count: got %b exp 0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        step(); drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h500, 32'h0);
        step(); drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h504, 32'h0); #2;
        checks++; if (haddr !== 32'h500) begin errors++; $display("FAIL b2b_a0: got %h exp 500", haddr); end
        step(); drive_req(1'b0, HSIZE_HALF, 1'b0, 32'h508, 32'h0); hrdata = 32'hA0; #2;
        checks++; if (haddr !== 32'h504 || resp_valid !== 1'b1 || resp_rdata !== 32'hA0) begin errors++; $display("FAIL b2b_r0: got %h/%b/%h exp 504/1/a0", haddr, resp_valid, resp_rdata); end
        step(); req_valid = 1'b0; hrdata = 32'hA1; #2;
        checks++; if (haddr !== 32'h508 || hsize !== 3'b001 || resp_valid !== 1'b1 || resp_rdata !== 32'hA1) begin errors++; $display("FAIL b2b_r1: got %h/%b/%b/%h exp 508/001/1/a1", haddr, hsize, resp_valid, resp_rdata); end
        step(); hrdata = 32'hA2; #2;
        checks++; if (htrans !== 2'b00 || resp_valid !== 1'b1 || resp_rdata !== 32'hA2) begin errors++; $display("FAIL b2b_r2: got %h/%b/%h exp 0/1/a2", htrans, resp_valid, resp_rdata); end
        step(); drive_idle();
    endtask

    task automatic test_wait_states();
        step(); drive_req(1'b1, HSIZE_WORD, 1'b0, 32'h300, 32'hA5A5_0001);
        step(); drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h304, 32'h0);
        step(); drive_idle(); hready = 1'b0; held_addr = haddr; held_wdata = hwdata;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #2;
            checks++; if (haddr !== 32'h304 || htrans !== 2'b10 || hwdata !== 32'hA5A5_0001) begin errors++; $display("FAIL ws_st_hold%0d: got %h/%h/%h exp 304/2/a5a50001", i, haddr, htrans, hwdata); end
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL ws_st_stall%0d: got %b/%b exp 0/0", i, req_ready, resp_valid); end
        end
        step(); hready = 1'b1; #2;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL ws_st_resp: got %b/%b exp 1/0", resp_valid, resp_err); end
        step(); hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #2;
            checks++; if (htrans !== 2'b00 || haddr !== 32'h304 || hwdata !== 32'h0) begin errors++; $display("FAIL ws_ld_hold%0d: got %h/%h/%h exp 0/304/0", i, htrans, haddr, hwdata); end
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL ws_ld_stall%0d: got %b/%b exp 0/0", i, req_ready, resp_valid); end
        end
        step(); hready = 1'b1; hrdata = 32'h55AA_33CC; #2;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h55AA_33CC) begin errors++; $display("FAIL ws_ld_resp: got %b/%h exp 1/55aa33cc", resp_valid, resp_rdata); end
        step(); drive_idle(); #2;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ws_resp_once: got %b exp 0", resp_valid); end
    endtask

    task automatic test_error_cancel();
        issued_204 = 1'b0;
        step(); drive_req(1'b1, HSIZE_WORD, 1'b0, 32'h200, 32'h1234_5678);
        step(); drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h204, 32'h0);
        step(); drive_idle(); hready = 1'b0; hresp = 1'b1; #2;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL err1_stall: got %b/%b exp 0/0", resp_valid, req_ready); end
        step(); hready = 1'b1; hresp = 1'b1; #2;
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL err2_htrans: got %h exp 0", htrans); end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL err2_resp: got %b/%b exp 1/1", resp_valid, resp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL err2_ready: got %b exp 0", req_ready); end
        step(); hresp = 1'b0; drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h600, 32'h0); #2;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL cancel_resp: got %b/%b exp 1/1", resp_valid, resp_err); end
        checks++; if (req_ready !== 1'b0 || htrans !== 2'b00) begin errors++; $display("FAIL cancel_block: got %b/%h exp 0/0", req_ready, htrans); end
        step(); drive_idle(); #2;
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1 || htrans !== 2'b00) begin errors++; $display("FAIL err_after: got %b/%b/%b/%h exp 0/0/1/0", resp_valid, resp_err, req_ready, htrans); end
        step(); #2;
        checks++; if (issued_204 !== 1'b0) begin errors++; $display("FAIL err_204_issued: got %b exp 0", issued_204); end
    endtask

    task automatic test_reset_mid();
        step(); drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h400, 32'h0);
        step(); drive_idle();
        step(); hready = 1'b0; #1;
        reset = 1'b0; #1;
        checks++; if (htrans !== 2'b00 || haddr !== 32'h0) begin errors++; $display("FAIL rm_async: got %h/%h exp 0/0", htrans, haddr); end
        hready = 1'b1; #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_resp: got %b exp 0", resp_valid); end
        step(); #2;
        checks++; if (resp_valid !== 1'b0 || htrans !== 2'b00) begin errors++; $display("FAIL rm_hold: got %b/%h exp 0/0", resp_valid, htrans); end
        reset = 1'b1;
        drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h408, 32'h0); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_release: got %b/%b exp 0/1", resp_valid, req_ready); end
        step(); drive_idle(); #2;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h408 || resp_valid !== 1'b0) begin errors++; $display("FAIL rm_ap: got %h/%h/%b exp 2/408/0", htrans, haddr, resp_valid); end
        step(); hrdata = 32'h1357_2468; #2;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1357_2468 || resp_err !== 1'b0) begin errors++; $display("FAIL rm_dp: got %b/%h/%b exp 1/13572468/0", resp_valid, resp_rdata, resp_err); end
        step(); drive_idle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step(); drive_idle(); #2;
            checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL idle_htrans%0d: got %h exp 0", i, htrans); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp%0d: got %b exp 0", i, resp_valid); end
            checks++; if (hprot !== 4'b0011) begin errors++; $display("FAIL idle_hprot%0d: got %b exp 0011", i, hprot); end
        end
        // hready low with AP empty: nothing is accepted
        step(); hready = 1'b0; drive_req(1'b0, HSIZE_WORD, 1'b0, 32'h700, 32'h0); #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL idle_stall_ready: got %b exp 0", req_ready); end
        step(); drive_idle(); #2;
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL idle_stall_htrans: got %h exp 0", htrans); end
    endtask

    // sequence and report
    initial begin
        issued_204 = 1'b0;
        test_reset();
        test_single_read();
        test_pipelined();
        test_back_to_back();
        test_wait_states();
        test_error_cancel();
        test_reset_mid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
